cordic_ci_issuer: RTL

Host-side initiator for the cosine CORDIC custom-instruction interface. It accepts raw 32-bit angle words from a streaming source, buffers them, and issues them one at a time to a variable-latency accelerator using the start/dataa/done/result handshake. It captures each 21-bit result and presents it on a valid/ready output. A watchdog aborts and resets an accelerator that never raises done. It lets the accelerator be exercised and timed on hardware without a CPU.

---
 rtl/cordic_ci_issuer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/cordic_ci_issuer.sv
// cordic_ci_issuer
// Streams 32-bit angle words from a valid/ready source into a small FIFO.
// Issues them one at a time to a variable-latency CORDIC custom-instruction
// accelerator over the start/dataa/done/result handshake, and presents each
// captured result on a valid/ready output.
// A watchdog aborts and resets an accelerator that never signals done, so
// the accelerator can be exercised and timed on hardware without a CPU.
module cordic_ci_issuer #(
    parameter int DATA_W     = 32,
    parameter int RES_W      = 21,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              ci_clk_en,
    output logic              ci_reset,
    output logic              ci_start,
    output logic [DATA_W-1:0] ci_dataa,
    input  logic              ci_done,
    input  logic [RES_W-1:0]  ci_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RES_W-1:0]  out_data,
    output logic              out_timeout,
    output logic              busy,
    output logic              err_sticky
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    // The watchdog holds the number of completed WAIT cycles, so the abort
    // decision is taken in the WAIT cycle where it would reach TIMEOUT.
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ABORT
    } state_t;

    state_t            state;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [15:0]       watchdog;

    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              slot_free;
    logic              capture;
    logic              timeout_hit;

    // Handshake qualifiers derived from registered state only
    assign fifo_empty  = (count == '0);
    assign in_ready    = (count != FULL_CNT);
    assign push        = in_valid && in_ready;
    // Output slot is free when empty or being drained this very cycle
    assign slot_free   = !out_valid || out_ready;
    assign pop         = (state == S_IDLE) && !fifo_empty && slot_free;
    // done is only meaningful while a request is outstanding
    assign capture     = ci_done && ((state == S_ISSUE) || (state == S_WAIT));
    // done in the last WAIT cycle beats the timeout
    assign timeout_hit = (state == S_WAIT) && !ci_done && (watchdog == WD_LAST);
    assign ci_reset    = reset || (state == S_ABORT);
    assign busy        = (state != S_IDLE) || !fifo_empty;

    // FIFO storage: data only, no reset needed
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy; power-of-two depth wraps pointers naturally
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Accelerator clock runs in every cycle once reset is released
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ci_clk_en <= 1'b0;
        end else begin
            ci_clk_en <= 1'b1;
        end
    end

    // Issue FSM with registered strobe, operand, result slot and error flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            ci_start    <= 1'b0;
            ci_dataa    <= '0;
            watchdog    <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_timeout <= 1'b0;
            err_sticky  <= 1'b0;
        end else begin
            ci_start <= 1'b0;
            // A capture below overrides this drain in the same cycle
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        ci_dataa <= fifo_mem[rd_ptr];
                        ci_start <= 1'b1;
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    watchdog <= '0;
                    if (capture) begin
                        out_data    <= ci_result;
                        out_timeout <= 1'b0;
                        out_valid   <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    watchdog <= watchdog + 1'b1;
                    if (capture) begin
                        out_data    <= ci_result;
                        out_timeout <= 1'b0;
                        out_valid   <= 1'b1;
                        state       <= S_IDLE;
                    end else if (timeout_hit) begin
                        out_data    <= '0;
                        out_timeout <= 1'b1;
                        out_valid   <= 1'b1;
                        err_sticky  <= 1'b1;
                        state       <= S_ABORT;
                    end
                end
                S_ABORT: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
